load_store_ctrl: RTL and testbench
==================================

// Module: load_store_ctrl
// PURPOSE
//  Multicycle memory-access sequencer for lw/lh/lb/sw/sh/sb. Started by the main control FSM
//  once the effective address is in place. Drives memory write, MDR write and register-file write.
//  Selects the sizes for the load-size mux (ls_sel) and the store-merge mux (ss_sel).
//  Sub-word stores run as read-modify-write. Main FSM waits on done.
// PARAMETERS
//  MEM_LAT  1  memory read latency in cycles (0..15); MemData valid MEM_LAT cycles after address
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  asynchronous, active-high reset
//  start        in   1  begin access; sampled only in IDLE
//  op           in   3  000 lw, 001 lh, 010 lb, 100 sw, 101 sh, 110 sb; others illegal
//  addr_lo      in   2  effective address bits [1:0]
//  mem_wr       out  1  memory write strobe
//  mdr_wr       out  1  MDR load enable (captures MemData)
//  rf_wr        out  1  register-file write enable (load result)
//  ls_sel       out  2  load-size mux: 01 word, 10 half (zero-ext), 11 byte (zero-ext)
//  ss_sel       out  2  store-merge mux: 00 word, 01 half, 10 byte
//  busy         out  1  high in every state except IDLE
//  done         out  1  one-cycle completion pulse
//  illegal_op   out  1  one-cycle pulse, with done, on illegal op
//  misalign_exc out  1  one-cycle pulse, with done, on misaligned access (see CONFIGURATION)
// BEHAVIOUR
//  Reset state:
//   - FSM in IDLE; wait counter 0; ls_sel=01; ss_sel=00
//   - all strobes (mem_wr, mdr_wr, rf_wr, done, illegal_op, misalign_exc) 0; busy 0
//  op latching:
//   - op is latched on the accepted start; ls_sel/ss_sel come from the latched op
//   - ls_sel/ss_sel hold their value after done until the next accepted start
//  States: IDLE, RD_WAIT, RD_LATCH, LD_WB, ST_WR, FAULT.
//  IDLE, start=1:
//   - load                  -> RD_WAIT (RD_LATCH if MEM_LAT=0)
//   - sw                    -> ST_WR
//   - sh/sb                 -> RD_WAIT (RD_LATCH if MEM_LAT=0)
//   - illegal op            -> FAULT
//   - start while busy is ignored, not queued
//  RD_WAIT:
//   - counts MEM_LAT cycles, then -> RD_LATCH
//   - counter width $clog2(MEM_LAT+1); counter clears on exit
//  RD_LATCH: mdr_wr=1 for one cycle. Load -> LD_WB; sh/sb -> ST_WR.
//  LD_WB: rf_wr=1 and done=1 for one cycle -> IDLE.
//  ST_WR: mem_wr=1 and done=1 for one cycle -> IDLE.
//  FAULT: done=1 plus illegal_op or misalign_exc for one cycle; no mem/rf write -> IDLE.
//  Latency, start accepted in cycle 0:
//   - load / sh / sb: done in cycle MEM_LAT+2
//   - sw: done in cycle 1
//   - fault: done in cycle 1
//  Strobe rules:
//   - all strobes are registered-state decodes
//   - strobes are mutually exclusive, except: done with rf_wr, mem_wr, or a fault flag
//  Back-to-back: start may be high in the cycle after done; that start is accepted.
//  Reset mid-operation: immediate return to IDLE; strobes drop asynchronously; no partial write issued.
// CONFIGURATION
//  MISALIGN_EXC_EN defined:
//   - a legal op is misaligned when: lw/sw with addr_lo!=00, or lh/sh with addr_lo[0]=1
//   - misaligned op at start -> FAULT with misalign_exc=1
//   - in FAULT, mdr_wr/mem_wr/rf_wr stay 0
//   - an illegal op takes precedence (illegal_op only)
//  MISALIGN_EXC_EN undefined:
//   - addr_lo is ignored; misalign_exc is tied to 0
//   - misaligned accesses proceed normally
// TESTING
//  1 MEM_LAT=1, start lw:
//    - mdr_wr high in cycle 2; rf_wr+done in cycle 3; ls_sel=01; mem_wr never high
//  2 MEM_LAT=2, start sb:
//    - mdr_wr in cycle 3; mem_wr+done in cycle 4; ss_sel=10; rf_wr never high
//  3 start sw, then start lh in the cycle after done:
//    - mem_wr+done in cycle 1; lh accepted in cycle 2; ls_sel=10
//  4 op=111:
//    - done+illegal_op in cycle 1; no strobes
//    - start pulsed while busy during a lw is ignored (exactly one done)
//  5 MISALIGN_EXC_EN defined, lh with addr_lo=01:
//    - misalign_exc+done in cycle 1; no writes
//    - macro undefined: same stimulus completes a normal lh
//  6 reset asserted during RD_WAIT of sh:
//    - strobes 0 immediately; busy=0; no mem_wr after release; next sw completes in 1 cycle

Source files
------------

// File: rtl/load_store_ctrl.sv
// Multicycle load/store sequencer: read wait, MDR capture, writeback or read-modify-write store.
// Optional misalignment faulting is enabled by defining MISALIGN_EXC_EN.
module load_store_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [1:0] addr_lo,
    output logic       mem_wr,
    output logic       mdr_wr,
    output logic       rf_wr,
    output logic [1:0] ls_sel,
    output logic [1:0] ss_sel,
    output logic       busy,
    output logic       done,
    output logic       illegal_op,
    output logic       misalign_exc
);

    localparam int CW    = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int LASTI = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;
    localparam logic [CW-1:0] LAST = LASTI[CW-1:0];

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_LATCH, LD_WB, ST_WR, FAULT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          st_q;
    logic          is_illegal;
    logic          is_mis;

    assign is_illegal = (op[1:0] == 2'b11);

`ifdef MISALIGN_EXC_EN
    assign is_mis = ((op[1:0] == 2'b00) && (addr_lo != 2'b00)) ||
                    ((op[1:0] == 2'b01) && addr_lo[0]);
`else
    logic unused_addr;
    assign unused_addr = ^addr_lo;
    assign is_mis      = 1'b0;
`endif

    // Size selects decode from op[1:0] for both loads and stores.
    function automatic logic [1:0] lsel(input logic [1:0] sz);
        case (sz)
            2'b01:   lsel = 2'b10;
            2'b10:   lsel = 2'b11;
            default: lsel = 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] ssel(input logic [1:0] sz);
        case (sz)
            2'b01:   ssel = 2'b01;
            2'b10:   ssel = 2'b10;
            default: ssel = 2'b00;
        endcase
    endfunction

    // Strobes are registered alongside the state so each is a pure decode of the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            st_q         <= 1'b0;
            ls_sel       <= 2'b01;
            ss_sel       <= 2'b00;
            mem_wr       <= 1'b0;
            mdr_wr       <= 1'b0;
            rf_wr        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            illegal_op   <= 1'b0;
            misalign_exc <= 1'b0;
        end else begin
            mem_wr       <= 1'b0;
            mdr_wr       <= 1'b0;
            rf_wr        <= 1'b0;
            done         <= 1'b0;
            illegal_op   <= 1'b0;
            misalign_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        st_q   <= op[2];
                        ls_sel <= lsel(op[1:0]);
                        ss_sel <= ssel(op[1:0]);
                        busy   <= 1'b1;
                        if (is_illegal) begin
                            state      <= FAULT;
                            done       <= 1'b1;
                            illegal_op <= 1'b1;
                        end else if (is_mis) begin
                            state        <= FAULT;
                            done         <= 1'b1;
                            misalign_exc <= 1'b1;
                        end else if (op == 3'b100) begin
                            state  <= ST_WR;
                            mem_wr <= 1'b1;
                            done   <= 1'b1;
                        end else if (MEM_LAT == 0) begin
                            state  <= RD_LATCH;
                            mdr_wr <= 1'b1;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        state  <= RD_LATCH;
                        mdr_wr <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_LATCH: begin
                    done <= 1'b1;
                    if (st_q) begin
                        state  <= ST_WR;
                        mem_wr <= 1'b1;
                    end else begin
                        state <= LD_WB;
                        rf_wr <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed bench for load_store_ctrl: two instances (MEM_LAT=1 and MEM_LAT=2) share stimulus.
module tb_load_store_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [1:0] addr_lo;

    logic       mem_wr[2], mdr_wr[2], rf_wr[2], busy[2], done[2], ill[2], mis[2];
    logic [1:0] ls[2], ss[2];

    always #5 clk = ~clk;

    load_store_ctrl #(.MEM_LAT(1)) d1 (
        .clk(clk), .reset(rst), .start(start), .op(op), .addr_lo(addr_lo),
        .mem_wr(mem_wr[0]), .mdr_wr(mdr_wr[0]), .rf_wr(rf_wr[0]), .ls_sel(ls[0]), .ss_sel(ss[0]),
        .busy(busy[0]), .done(done[0]), .illegal_op(ill[0]), .misalign_exc(mis[0])
    );

    load_store_ctrl #(.MEM_LAT(2)) d2 (
        .clk(clk), .reset(rst), .start(start), .op(op), .addr_lo(addr_lo),
        .mem_wr(mem_wr[1]), .mdr_wr(mdr_wr[1]), .rf_wr(rf_wr[1]), .ls_sel(ls[1]), .ss_sel(ss[1]),
        .busy(busy[1]), .done(done[1]), .illegal_op(ill[1]), .misalign_exc(mis[1])
    );

    typedef struct {
        logic [2:0] op;
        logic [1:0] a;
        int done_c;
        int mdr_c;
        int rf;
        int mem;
        int ls;
        int ss;
        int ill;
        int mis;
    } vec_t;

    vec_t tbl[11];

    int checks = 0;
    int errors = 0;

    int r_done, r_ndone, r_mdr, r_rf, r_mem, r_ill, r_mis, r_ls, r_ss, r_busy1, r_excl;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issue one op in cycle 0 and trace instance d over cycles 1..10.
    task automatic run_op(input int d, input logic [2:0] o, input logic [1:0] a);
        @(posedge clk); #1;
        start = 1'b1; op = o; addr_lo = a;
        @(posedge clk); #1;
        start = 1'b0;
        r_done = -1; r_ndone = 0; r_mdr = -1; r_rf = 0; r_mem = 0;
        r_ill = 0; r_mis = 0; r_ls = -1; r_ss = -1; r_busy1 = 0; r_excl = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) r_busy1 = int'(busy[d]);
            if (mdr_wr[d] && r_mdr < 0) r_mdr = k;
            if (done[d]) begin
                r_ndone++;
                if (r_done < 0) begin
                    r_done = k; r_ls = int'(ls[d]); r_ss = int'(ss[d]);
                end
            end
            if (rf_wr[d])  r_rf  = 1;
            if (mem_wr[d]) r_mem = 1;
            if (ill[d])    r_ill = 1;
            if (mis[d])    r_mis = 1;
            if ((int'(mem_wr[d]) + int'(mdr_wr[d]) + int'(rf_wr[d]) > 1) ||
                ((ill[d] || mis[d]) && (mem_wr[d] || mdr_wr[d] || rf_wr[d])))
                r_excl = 1;
        end
    endtask

    initial begin
        int k0, nd0, nd1, rf0, mem0, bad;

        // Expected values for the MEM_LAT=1 instance.
        tbl[0]  = '{3'b000, 2'b00, 3,  2, 1, 0, 1, 0, 0, 0};
        tbl[1]  = '{3'b001, 2'b10, 3,  2, 1, 0, 2, 1, 0, 0};
        tbl[2]  = '{3'b010, 2'b11, 3,  2, 1, 0, 3, 2, 0, 0};
        tbl[3]  = '{3'b100, 2'b00, 1, -1, 0, 1, 1, 0, 0, 0};
        tbl[4]  = '{3'b101, 2'b10, 3,  2, 0, 1, 2, 1, 0, 0};
        tbl[5]  = '{3'b110, 2'b01, 3,  2, 0, 1, 3, 2, 0, 0};
        tbl[6]  = '{3'b111, 2'b00, 1, -1, 0, 0, -1, -1, 1, 0};
        tbl[7]  = '{3'b011, 2'b01, 1, -1, 0, 0, -1, -1, 1, 0};
`ifdef MISALIGN_EXC_EN
        tbl[8]  = '{3'b001, 2'b01, 1, -1, 0, 0, 2, 1, 0, 1};
        tbl[9]  = '{3'b000, 2'b10, 1, -1, 0, 0, 1, 0, 0, 1};
        tbl[10] = '{3'b100, 2'b11, 1, -1, 0, 0, 1, 0, 0, 1};
`else
        tbl[8]  = '{3'b001, 2'b01, 3,  2, 1, 0, 2, 1, 0, 0};
        tbl[9]  = '{3'b000, 2'b10, 3,  2, 1, 0, 1, 0, 0, 0};
        tbl[10] = '{3'b100, 2'b11, 1, -1, 0, 1, 1, 0, 0, 0};
`endif

        rst = 1'b1; start = 1'b0; op = 3'b000; addr_lo = 2'b00;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ls%0d", d), int'(ls[d]), 1);
            chk($sformatf("reset_ss%0d", d), int'(ss[d]), 0);
            chk($sformatf("reset_strobes%0d", d),
                int'({mem_wr[d], mdr_wr[d], rf_wr[d], busy[d], done[d], ill[d], mis[d]}), 0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(0, tbl[i].op, tbl[i].a);
            chk($sformatf("v%0d_done_cycle", i), r_done, tbl[i].done_c);
            chk($sformatf("v%0d_done_count", i), r_ndone, 1);
            chk($sformatf("v%0d_mdr_cycle", i), r_mdr, tbl[i].mdr_c);
            chk($sformatf("v%0d_rf_wr", i), r_rf, tbl[i].rf);
            chk($sformatf("v%0d_mem_wr", i), r_mem, tbl[i].mem);
            chk($sformatf("v%0d_illegal", i), r_ill, tbl[i].ill);
            chk($sformatf("v%0d_misalign", i), r_mis, tbl[i].mis);
            chk($sformatf("v%0d_busy", i), r_busy1, 1);
            chk($sformatf("v%0d_exclusive", i), r_excl, 0);
            if (tbl[i].ls >= 0) chk($sformatf("v%0d_ls_sel", i), r_ls, tbl[i].ls);
            if (tbl[i].ss >= 0) chk($sformatf("v%0d_ss_sel", i), r_ss, tbl[i].ss);
        end

        // MEM_LAT=2: sb and lw.
        run_op(1, 3'b110, 2'b00);
        chk("sb_lat2_mdr_cycle", r_mdr, 3);
        chk("sb_lat2_done_cycle", r_done, 4);
        chk("sb_lat2_ss_sel", r_ss, 2);
        chk("sb_lat2_mem_wr", r_mem, 1);
        chk("sb_lat2_rf_wr", r_rf, 0);
        run_op(1, 3'b000, 2'b00);
        chk("lw_lat2_mdr_cycle", r_mdr, 3);
        chk("lw_lat2_done_cycle", r_done, 4);
        chk("lw_lat2_rf_wr", r_rf, 1);
        chk("lw_lat2_mem_wr", r_mem, 0);

        // sw, then lh started in the cycle right after done.
        @(posedge clk); #1;
        start = 1'b1; op = 3'b100; addr_lo = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_sw_done", int'(done[0]), 1);
        chk("b2b_sw_mem_wr", int'(mem_wr[0]), 1);
        @(posedge clk); #1;
        start = 1'b1; op = 3'b001;
        @(negedge clk);
        chk("b2b_idle_busy", int'(busy[0]), 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_lh_busy", int'(busy[0]), 1);
        chk("b2b_lh_ls_sel", int'(ls[0]), 2);
        k0 = -1;
        for (int k = 4; k <= 12; k++) begin
            @(negedge clk);
            if (done[0] && k0 < 0) k0 = k;
        end
        chk("b2b_lh_done_cycle", k0, 5);

        // start re-pulsed while a lw is in flight must be ignored.
        @(posedge clk); #1;
        start = 1'b1; op = 3'b000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 3'b100;
        @(posedge clk); #1;
        start = 1'b0;
        nd0 = 0; nd1 = 0; rf0 = 0; mem0 = 0;
        for (int k = 3; k <= 12; k++) begin
            @(negedge clk);
            nd0 += int'(done[0]); nd1 += int'(done[1]);
            rf0 |= int'(rf_wr[0]); mem0 |= int'(mem_wr[0]);
        end
        chk("busy_start_done_count_lat1", nd0, 1);
        chk("busy_start_done_count_lat2", nd1, 1);
        chk("busy_start_rf_wr", rf0, 1);
        chk("busy_start_mem_wr", mem0, 0);

        // Reset asserted while the MEM_LAT=2 instance is in RD_WAIT of sh.
        @(posedge clk); #1;
        start = 1'b1; op = 3'b101; addr_lo = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy_before", int'(busy[1]), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", int'(busy[1]), 0);
        chk("rst_mid_strobes", int'({mem_wr[1], mdr_wr[1], rf_wr[1], done[1]}), 0);
        chk("rst_mid_ls_sel", int'(ls[1]), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bad |= int'(mem_wr[1] || mdr_wr[1] || done[1] || busy[1]);
        end
        chk("rst_mid_no_write_after", bad, 0);
        run_op(1, 3'b100, 2'b00);
        chk("rst_mid_sw_done_cycle", r_done, 1);
        chk("rst_mid_sw_mem_wr", r_mem, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
